// File: rtl/sm_rd_engine_pkg.sv
// Shared-memory buffer manager types used by the read/free engine:
// pointers, cells, commands and the read-engine state encoding.
package sm_rd_engine_pkg;

  localparam int SM_PTR_W  = 8;
  localparam int SM_DATA_W = 32;

  typedef logic [SM_PTR_W-1:0] sm_ptr_t;

  typedef enum logic {
    SM_CMD_READ = 1'b0,
    SM_CMD_FREE = 1'b1
  } sm_cmd_code_t;

  typedef struct packed {
    sm_cmd_code_t code;
    sm_ptr_t      ptr;
  } sm_cmd_t;

  typedef struct packed {
    logic                 eop;
    sm_ptr_t              next;
    logic [SM_DATA_W-1:0] data;
  } sm_cell_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } sm_rd_state_t;

endpackage

// File: rtl/sm_rd_engine_if.sv
// Command, memory-read, data-out and free channels of the read engine.
// Suffixes _i/_o are from the engine's point of view (master modport).
interface sm_rd_engine_if;
  import sm_rd_engine_pkg::*;

  // Every channel: a transfer happens on a cycle where valid and ready are
  // both high; valid and its payload hold stable until that transfer.
  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  sm_cmd_t              cmd_i;
  logic                 mem_rd_en_o;
  sm_ptr_t              mem_rd_addr_o;
  sm_cell_t             mem_rd_data_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [SM_DATA_W-1:0] out_data_o;
  logic                 out_sop_o;
  logic                 out_eop_o;
  logic                 free_valid_o;
  logic                 free_ready_i;
  sm_ptr_t              free_ptr_o;
  logic                 done_o;
  logic                 err_o;

  modport master (
    input  cmd_valid_i, cmd_i, mem_rd_data_i, out_ready_i, free_ready_i,
    output cmd_ready_o, mem_rd_en_o, mem_rd_addr_o, out_valid_o, out_data_o,
           out_sop_o, out_eop_o, free_valid_o, free_ptr_o, done_o, err_o
  );

  modport slave (
    output cmd_valid_i, cmd_i, mem_rd_data_i, out_ready_i, free_ready_i,
    input  cmd_ready_o, mem_rd_en_o, mem_rd_addr_o, out_valid_o, out_data_o,
           out_sop_o, out_eop_o, free_valid_o, free_ptr_o, done_o, err_o
  );

endinterface

// File: rtl/sm_rd_engine.sv
// Walks a stored packet's cell chain: READ streams data words, FREE releases
// cell pointers. Define SM_RD_AUTO_FREE_EN to make READ also release cells.
module sm_rd_engine
  import sm_rd_engine_pkg::*;
#(
  parameter int MAX_CELLS = 64
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  sm_rd_engine_if.master bus,
  output sm_rd_state_t dbg_state_o
);

  localparam int CNT_W = $clog2(MAX_CELLS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CELLS);

  sm_rd_state_t   r_state;
  sm_cmd_code_t   r_code;
  sm_ptr_t        r_cur_ptr;
  sm_cell_t       r_cell;
  logic [CNT_W-1:0] r_cnt;
  logic           r_sop_pend;
  logic           r_out_done;
  logic           r_free_done;

  logic w_hold, w_is_read, w_need_out, w_need_free;
  logic w_out_valid, w_free_valid, w_out_hs, w_free_hs;
  logic w_beat_done, w_limit, w_next;

  assign w_hold     = (r_state == ST_HOLD);
  assign w_is_read  = (r_code == SM_CMD_READ);
  assign w_need_out = w_is_read;
`ifdef SM_RD_AUTO_FREE_EN
  assign w_need_free = 1'b1;
`else
  assign w_need_free = ~w_is_read;
`endif

  assign w_out_valid  = w_hold & w_need_out  & ~r_out_done;
  assign w_free_valid = w_hold & w_need_free & ~r_free_done;
  assign w_out_hs     = w_out_valid  & bus.out_ready_i;
  assign w_free_hs    = w_free_valid & bus.free_ready_i;

  // A beat finishes once each required channel has transferred, either in an
  // earlier HOLD cycle (sticky bit) or in this one.
  assign w_beat_done = w_hold
                     & (~w_need_out  | r_out_done  | w_out_hs)
                     & (~w_need_free | r_free_done | w_free_hs);
  assign w_limit = (r_cnt == CNT_MAX);
  assign w_next  = w_beat_done & ~r_cell.eop & ~w_limit;

  assign bus.cmd_ready_o   = (r_state == ST_IDLE);
  assign bus.mem_rd_en_o   = (r_state == ST_RD) | w_next;
  assign bus.mem_rd_addr_o = (r_state == ST_RD) ? r_cur_ptr :
                             (w_next ? r_cell.next : '0);
  assign bus.out_valid_o   = w_out_valid;
  assign bus.out_data_o    = w_out_valid ? r_cell.data : '0;
  assign bus.out_sop_o     = w_out_valid & r_sop_pend;
  assign bus.out_eop_o     = w_out_valid & r_cell.eop;
  assign bus.free_valid_o  = w_free_valid;
  assign bus.free_ptr_o    = w_free_valid ? r_cur_ptr : '0;
  assign bus.done_o        = w_beat_done & (r_cell.eop | w_limit);
  assign bus.err_o         = w_beat_done & ~r_cell.eop & w_limit;
  assign dbg_state_o       = r_state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_code      <= SM_CMD_READ;
      r_cur_ptr   <= '0;
      r_cell      <= '0;
      r_cnt       <= '0;
      r_sop_pend  <= 1'b0;
      r_out_done  <= 1'b0;
      r_free_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid_i) begin
            r_code     <= bus.cmd_i.code;
            r_cur_ptr  <= bus.cmd_i.ptr;
            r_cnt      <= '0;
            r_sop_pend <= 1'b1;
            r_state    <= ST_RD;
          end
        end
        ST_RD: r_state <= ST_WAIT;
        ST_WAIT: begin
          r_cell      <= bus.mem_rd_data_i;
          r_cnt       <= w_limit ? r_cnt : r_cnt + 1'b1;
          r_out_done  <= 1'b0;
          r_free_done <= 1'b0;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (w_beat_done) begin
            r_out_done  <= 1'b0;
            r_free_done <= 1'b0;
            if (w_next) begin
              r_cur_ptr  <= r_cell.next;
              r_sop_pend <= 1'b0;
              r_state    <= ST_WAIT;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            if (w_out_hs)  r_out_done  <= 1'b1;
            if (w_free_hs) r_free_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_rd_engine.sv
// Directed bench for sm_rd_engine with a 1-cycle-latency cell memory model.
module tb_sm_rd_engine;
  import sm_rd_engine_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  sm_rd_state_t dbg_state;
  int cyc = 0;
  int n_total = 0;
  int n_bad = 0;

  sm_rd_engine_if bus ();

  sm_rd_engine #(.MAX_CELLS(64)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model: request seen mid-cycle, data presented from the next edge
  sm_cell_t mem [256];
  logic     mem_req = 1'b0;
  sm_ptr_t  mem_addr = '0;
  always @(negedge clk) begin
    mem_req  <= bus.mem_rd_en_o;
    mem_addr <= bus.mem_rd_addr_o;
  end
  always @(posedge clk) if (mem_req) bus.mem_rd_data_i <= mem[mem_addr];

  // scoreboard state
  logic [33:0] exp_q[$];
  logic [33:0] obs_out[$];
  logic [7:0]  exp_free[$];
  logic [7:0]  obs_free[$];
  int out_cyc[$];
  int free_cyc[$];
  int rd_cyc[$];
  int n_reads = 0;
  int n_done = 0;
  int acc_cyc = 0;
  logic last_err = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_rd_en_o) begin n_reads++; rd_cyc.push_back(cyc); end
    if (bus.out_valid_o && bus.out_ready_i) begin
      obs_out.push_back({bus.out_sop_o, bus.out_eop_o, bus.out_data_o});
      out_cyc.push_back(cyc);
    end
    if (bus.free_valid_o && bus.free_ready_i) begin
      obs_free.push_back(bus.free_ptr_o);
      free_cyc.push_back(cyc);
    end
    if (bus.done_o) begin n_done++; last_err = bus.err_o; end
    if (bus.cmd_valid_i && bus.cmd_ready_o) acc_cyc = cyc;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete(); obs_out.delete(); exp_free.delete(); obs_free.delete();
    out_cyc.delete(); free_cyc.delete(); rd_cyc.delete(); n_reads = 0;
  endtask

  task automatic send_cmd(input sm_cmd_code_t code, input sm_ptr_t ptr);
    int k = 0;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_i = '{code: code, ptr: ptr};
    while (!bus.cmd_ready_o && k < 100) begin @(posedge clk); #1; k++; end
    check("cmd_accept_timeout", 64'(k < 100), 64'd1);
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int start = n_done;
    int k = 0;
    while (n_done == start && k < limit) begin @(negedge clk); k++; end
    check(tag, 64'(n_done - start), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic cmp_streams(input string tag);
    check({tag, "_nout"}, 64'(obs_out.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_out.size(); i++)
      check({tag, "_beat"}, 64'(obs_out[i]), 64'(exp_q[i]));
    check({tag, "_nfree"}, 64'(obs_free.size()), 64'(exp_free.size()));
    for (int i = 0; i < exp_free.size() && i < obs_free.size(); i++)
      check({tag, "_fptr"}, 64'(obs_free[i]), 64'(exp_free[i]));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = '{eop: 1'b0, next: 8'h22, data: 32'hA000_0001};
    mem[8'h22] = '{eop: 1'b0, next: 8'h05, data: 32'hA000_0002};
    mem[8'h05] = '{eop: 1'b1, next: 8'h00, data: 32'hA000_0003};
    mem[8'hFF] = '{eop: 1'b1, next: 8'h00, data: 32'hDEAD_BEEF};
    mem[8'h07] = '{eop: 1'b0, next: 8'h07, data: 32'h0000_0777};
    mem[8'h00] = '{eop: 1'b0, next: 8'h30, data: 32'hF000_0000};
    mem[8'h30] = '{eop: 1'b1, next: 8'h00, data: 32'hF000_0030};
    bus.cmd_valid_i = 1'b0; bus.cmd_i = '0; bus.mem_rd_data_i = '0;
    bus.out_ready_i = 1'b1; bus.free_ready_i = 1'b1;

    // reset state
    repeat (3) @(posedge clk); #1;
    check("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
    check("rst_outs", 64'({bus.out_valid_o, bus.free_valid_o, bus.mem_rd_en_o, bus.done_o, bus.err_o}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;

    // 1: READ of 3-cell chain
    clear_sb();
    exp_q.push_back({1'b1, 1'b0, 32'hA000_0001});
    exp_q.push_back({1'b0, 1'b0, 32'hA000_0002});
    exp_q.push_back({1'b0, 1'b1, 32'hA000_0003});
`ifdef SM_RD_AUTO_FREE_EN
    exp_free.push_back(8'h10); exp_free.push_back(8'h22); exp_free.push_back(8'h05);
`endif
    send_cmd(SM_CMD_READ, 8'h10);
    wait_done("t1_done", 50);
    check("t1_err", 64'(last_err), 64'd0);
    cmp_streams("t1");
    if (out_cyc.size() == 3) begin
      check("t1_latency", 64'(out_cyc[0] - acc_cyc), 64'd3);
      check("t1_gap1", 64'(out_cyc[1] - out_cyc[0]), 64'd2);
      check("t1_gap2", 64'(out_cyc[2] - out_cyc[1]), 64'd2);
    end

    // 2: FREE of same chain, 4-cycle stall on the second cell
    clear_sb();
    exp_free.push_back(8'h10); exp_free.push_back(8'h22); exp_free.push_back(8'h05);
    send_cmd(SM_CMD_FREE, 8'h10);
    begin
      int k = 0;
      while (obs_free.size() < 1 && k < 50) begin @(negedge clk); k++; end
      @(posedge clk); #1; bus.free_ready_i = 1'b0;
      k = 0;
      while (!bus.free_valid_o && k < 50) begin @(negedge clk); k++; end
      for (int i = 0; i < 4; i++) begin
        check("t2_stall_valid", 64'(bus.free_valid_o), 64'd1);
        check("t2_stall_ptr", 64'(bus.free_ptr_o), 64'h22);
        @(negedge clk);
      end
      @(posedge clk); #1; bus.free_ready_i = 1'b1;
    end
    wait_done("t2_done", 50);
    check("t2_err", 64'(last_err), 64'd0);
    cmp_streams("t2");

    // 3: single-cell READ at top pointer
    clear_sb();
    exp_q.push_back({1'b1, 1'b1, 32'hDEAD_BEEF});
`ifdef SM_RD_AUTO_FREE_EN
    exp_free.push_back(8'hFF);
`endif
    send_cmd(SM_CMD_READ, 8'hFF);
    wait_done("t3_done", 50);
    cmp_streams("t3");

    // 4: self-loop terminated by the chain-length guard
    clear_sb();
    send_cmd(SM_CMD_READ, 8'h07);
    wait_done("t4_done", 300);
    check("t4_err", 64'(last_err), 64'd1);
    check("t4_reads", 64'(n_reads), 64'd64);
    check("t4_nout", 64'(obs_out.size()), 64'd64);
    check("t4_idle", 64'({dbg_state, bus.cmd_ready_o}), 64'({ST_IDLE, 1'b1}));

    // 5: reset mid-chain while out_valid is high
    clear_sb();
    bus.out_ready_i = 1'b0;
    send_cmd(SM_CMD_READ, 8'h10);
    begin
      int k = 0;
      while (!bus.out_valid_o && k < 50) begin @(negedge clk); k++; end
      check("t5_valid_seen", 64'(bus.out_valid_o), 64'd1);
    end
    @(posedge clk); #1; rst_n = 1'b0; bus.out_ready_i = 1'b1; #1;
    check("t5_rst_outs", 64'({bus.out_valid_o, bus.free_valid_o, bus.mem_rd_en_o, bus.done_o}), 64'd0);
    check("t5_rst_ready", 64'(bus.cmd_ready_o), 64'd1);
    repeat (3) @(posedge clk); #1;
    check("t5_no_beats", 64'(obs_out.size() + obs_free.size()), 64'd0);
    rst_n = 1'b1;
    clear_sb();
    exp_q.push_back({1'b1, 1'b1, 32'hDEAD_BEEF});
`ifdef SM_RD_AUTO_FREE_EN
    exp_free.push_back(8'hFF);
`endif
    send_cmd(SM_CMD_READ, 8'hFF);
    wait_done("t5_done", 50);
    cmp_streams("t5");

`ifdef SM_RD_AUTO_FREE_EN
    // 6: READ with auto-free, free handshake lagging the out handshake
    clear_sb();
    bus.free_ready_i = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 32'hF000_0000});
    exp_q.push_back({1'b0, 1'b1, 32'hF000_0030});
    exp_free.push_back(8'h00); exp_free.push_back(8'h30);
    send_cmd(SM_CMD_READ, 8'h00);
    begin
      int k = 0;
      while (obs_out.size() < 1 && k < 50) begin @(negedge clk); k++; end
      repeat (2) @(posedge clk); #1;
      check("t6_stalled_reads", 64'(n_reads), 64'd1);
      bus.free_ready_i = 1'b1;
    end
    wait_done("t6_done", 50);
    cmp_streams("t6");
    if (rd_cyc.size() == 2 && free_cyc.size() == 2)
      check("t6_read_after_free", 64'(rd_cyc[1]), 64'(free_cyc[0]));
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
